// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the Wishbone classic-cycle memory slave.
//   state_e  : slave FSM states (IDLE, WAIT, RESP)
//   resp_e   : termination kind latched at acceptance (NONE, ACK, ERR, RTY)
//   WAIT_W   : width of the wait-state down-counter (0..15 wait states)
//   classify : maps the acceptance-time conditions onto a termination kind
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_ACK,
    RESP_ERR,
    RESP_RTY
  } resp_e;

  // A retry request overrides everything; an unreachable word or an empty
  // lane select is an error; anything else is a normal acknowledge.
  function automatic resp_e classify(input logic rty,
                                     input logic out_of_range,
                                     input logic no_lanes);
    if (rty)                         return RESP_RTY;
    else if (out_of_range || no_lanes) return RESP_ERR;
    else                             return RESP_ACK;
  endfunction

endpackage

// File: rtl/wb_slave_bytemem.sv
// -----------------------------------------------------------------------------
// wb_slave_bytemem
// DEPTH x (DW data + TW tag) storage with byte-enabled synchronous write and a
// registered read port.
//   clk      : clock
//   we_i     : write strobe; bytes selected by wsel_i are written, tag always
//   re_i     : read strobe; rdata_o/rtag_o update on the following edge
//   addr_i   : word index
//   wdata_i  : write data
//   wsel_i   : byte-lane select
//   wtag_i   : tag stored alongside the written word
//   rdata_o  : registered read data
//   rtag_o   : registered read tag
// -----------------------------------------------------------------------------
module wb_slave_bytemem #(
  parameter int DW    = 64,
  parameter int TW    = 16,
  parameter int DEPTH = 256,
  parameter int MAW   = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [MAW-1:0]    addr_i,
  input  logic [DW-1:0]     wdata_i,
  input  logic [DW/8-1:0]   wsel_i,
  input  logic [TW-1:0]     wtag_i,
  output logic [DW-1:0]     rdata_o,
  output logic [TW-1:0]     rtag_o
);

  logic [DW-1:0] mem_data_q [DEPTH];
  logic [TW-1:0] mem_tag_q  [DEPTH];
  logic [DW-1:0] rdata_q;
  logic [TW-1:0] rtag_q;

  // NOTE: the array has no reset so it maps onto plain RAM and survives both
  // resets; the read register needs none because the top gates it with ACK.
  // NOTE: non-blocking assignments keep the read of the old word and the write
  // of a new one on the same edge order-independent.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < DW/8; b++) begin
        if (wsel_i[b]) mem_data_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
      mem_tag_q[addr_i] <= wtag_i;
    end
    if (re_i) begin
      rdata_q <= mem_data_q[addr_i];
      rtag_q  <= mem_tag_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;
  assign rtag_o  = rtag_q;

endmodule

// File: rtl/wb_slave_mem.sv
// -----------------------------------------------------------------------------
// wb_slave_mem
// Wishbone B4 classic-cycle slave in front of a byte-enabled memory, with
// programmable wait states, ERR/RTY generation, a locked-burst fast path and
// an ACK transfer counter.
//   clk, rst                 : clock, asynchronous active-high reset
//   RST_I                    : Wishbone synchronous reset (memory retained)
//   CYC_I, STB_I, WE_I, LOCK_I : cycle, strobe, write enable, lock
//   ADR_I, DAT_I, SEL_I      : byte address, write data, byte-lane select
//   TGA_I, TGC_I, TGD_I      : address/cycle tags (unused), data tag (stored)
//   rty_req                  : force RTY for the request accepted this cycle
//   DAT_O, TGD_O             : read data and tag, zero unless ACKing a read
//   ACK_O, ERR_O, RTY_O      : one-cycle, mutually exclusive terminations
//   xfer_cnt                 : wrapping count of ACK-terminated transfers
// -----------------------------------------------------------------------------
module wb_slave_mem
  import wb_pkg::*;
#(
  parameter int DW          = 64,
  parameter int AW          = 64,
  parameter int TW          = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RST_I,
  input  logic              CYC_I,
  input  logic              STB_I,
  input  logic              WE_I,
  input  logic              LOCK_I,
  input  logic [AW-1:0]     ADR_I,
  input  logic [DW-1:0]     DAT_I,
  input  logic [DW/8-1:0]   SEL_I,
  input  logic [TW-1:0]     TGA_I,
  input  logic [TW-1:0]     TGC_I,
  input  logic [TW-1:0]     TGD_I,
  input  logic              rty_req,
  output logic [DW-1:0]     DAT_O,
  output logic [TW-1:0]     TGD_O,
  output logic              ACK_O,
  output logic              ERR_O,
  output logic              RTY_O,
  output logic [31:0]       xfer_cnt
);

  localparam int SW  = DW / 8;
  localparam int OFF = $clog2(SW);
  localparam int IW  = AW - OFF;
  localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  resp_e             resp_q;
  logic              we_q, lock_q;
  logic              lock_hist_q, lock_hist_d;
  logic [31:0]       xfer_q, xfer_d;
  logic [MAW-1:0]    addr_q;
  logic [DW-1:0]     dat_q;
  logic [SW-1:0]     sel_q;
  logic [TW-1:0]     tgd_q;

  logic [IW-1:0]     word_idx;
  resp_e             req_class;
  logic              accept, zero_wait, cap, enter_resp;

  logic              cur_we;
  resp_e             cur_resp;
  logic [MAW-1:0]    cur_addr;
  logic [DW-1:0]     cur_dat;
  logic [SW-1:0]     cur_sel;
  logic [TW-1:0]     cur_tgd;
  logic              mem_we, mem_re;
  logic [DW-1:0]     mem_rdata;
  logic [TW-1:0]     mem_rtag;

  // Address/cycle tags are reserved for external decode; the low address bits
  // below word granularity carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{TGA_I, TGC_I, ADR_I};

  assign word_idx  = ADR_I[AW-1:OFF];
  assign req_class = classify(rty_req, word_idx >= IW'(DEPTH), SEL_I == '0);
  assign accept    = (state_q == ST_IDLE) && CYC_I && STB_I && !RST_I;
  // Back-to-back locked transfers skip the wait states only after the previous
  // accepted transfer was itself locked and acknowledged.
  assign zero_wait = (WAIT_STATES == 0) || (LOCK_I && lock_hist_q);

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    lock_hist_d = lock_hist_q;
    xfer_d      = xfer_q;
    cap         = 1'b0;
    enter_resp  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cap         = 1'b1;
          lock_hist_d = 1'b0;
          if (zero_wait) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            wcnt_d  = WAIT_W'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (!CYC_I) begin
          state_d = ST_IDLE;
        end else if (wcnt_q == '0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        lock_hist_d = lock_q && (resp_q == RESP_ACK);
        if (resp_q == RESP_ACK) xfer_d = xfer_q + 32'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (RST_I) begin
      state_d     = ST_IDLE;
      lock_hist_d = 1'b0;
      xfer_d      = '0;
      cap         = 1'b0;
      enter_resp  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      resp_q      <= RESP_NONE;
      we_q        <= 1'b0;
      lock_q      <= 1'b0;
      lock_hist_q <= 1'b0;
      xfer_q      <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      lock_hist_q <= lock_hist_d;
      xfer_q      <= xfer_d;
      if (cap) begin
        resp_q <= req_class;
        we_q   <= WE_I;
        lock_q <= LOCK_I;
      end
    end
  end

  // Payload is only consumed behind the control registers, so it needs no reset.
  always_ff @(posedge clk) begin
    if (cap) begin
      addr_q <= word_idx[MAW-1:0];
      dat_q  <= DAT_I;
      sel_q  <= SEL_I;
      tgd_q  <= TGD_I;
    end
  end

  // With zero wait states the memory is accessed on the acceptance edge itself,
  // before the request has been captured, so the live inputs are used then.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_we   = WE_I;
      cur_resp = req_class;
      cur_addr = word_idx[MAW-1:0];
      cur_dat  = DAT_I;
      cur_sel  = SEL_I;
      cur_tgd  = TGD_I;
    end else begin
      cur_we   = we_q;
      cur_resp = resp_q;
      cur_addr = addr_q;
      cur_dat  = dat_q;
      cur_sel  = sel_q;
      cur_tgd  = tgd_q;
    end
  end

  assign mem_we = enter_resp && cur_we  && (cur_resp == RESP_ACK);
  assign mem_re = enter_resp && !cur_we && (cur_resp == RESP_ACK);

  wb_slave_bytemem #(
    .DW    (DW),
    .TW    (TW),
    .DEPTH (DEPTH),
    .MAW   (MAW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (cur_addr),
    .wdata_i (cur_dat),
    .wsel_i  (cur_sel),
    .wtag_i  (cur_tgd),
    .rdata_o (mem_rdata),
    .rtag_o  (mem_rtag)
  );

  assign ACK_O    = (state_q == ST_RESP) && (resp_q == RESP_ACK);
  assign ERR_O    = (state_q == ST_RESP) && (resp_q == RESP_ERR);
  assign RTY_O    = (state_q == ST_RESP) && (resp_q == RESP_RTY);
  assign DAT_O    = (ACK_O && !we_q) ? mem_rdata : '0;
  assign TGD_O    = (ACK_O && !we_q) ? mem_rtag  : '0;
  assign xfer_cnt = xfer_q;

endmodule

// File: tb/tb_wb_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_wb_slave_mem
// Self-checking bench for wb_slave_mem (DW=64, DEPTH=256, WAIT_STATES=2).
// Expected terminations, latencies, read data and the transfer count come from
// a transaction-level model: a word array, a count and a "last transfer was a
// locked ACK" flag.
// -----------------------------------------------------------------------------
module tb_wb_slave_mem;

  localparam int DW = 64, AW = 64, TW = 16, DEPTH = 256, WS = 2;

  logic          clk = 1'b0;
  logic          rst, RST_I, CYC_I, STB_I, WE_I, LOCK_I, rty_req;
  logic [AW-1:0] ADR_I;
  logic [DW-1:0] DAT_I;
  logic [7:0]    SEL_I;
  logic [TW-1:0] TGA_I, TGC_I, TGD_I;
  logic [DW-1:0] DAT_O;
  logic [TW-1:0] TGD_O;
  logic          ACK_O, ERR_O, RTY_O;
  logic [31:0]   xfer_cnt;

  wb_slave_mem #(.DW(DW), .AW(AW), .TW(TW), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .RST_I(RST_I), .CYC_I(CYC_I), .STB_I(STB_I),
    .WE_I(WE_I), .LOCK_I(LOCK_I), .ADR_I(ADR_I), .DAT_I(DAT_I), .SEL_I(SEL_I),
    .TGA_I(TGA_I), .TGC_I(TGC_I), .TGD_I(TGD_I), .rty_req(rty_req),
    .DAT_O(DAT_O), .TGD_O(TGD_O), .ACK_O(ACK_O), .ERR_O(ERR_O), .RTY_O(RTY_O),
    .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  // resp: 0 none/timeout, 1 ACK, 2 ERR, 3 RTY. bad: more than one termination
  // at once, or read data/tag non-zero outside a read ACK.
  typedef struct packed {
    logic [1:0]  resp;
    logic [7:0]  lat;
    logic [63:0] rd;
    logic [15:0] rt;
    logic        bad;
  } xres_t;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_data [DEPTH];
  logic [15:0] m_tag  [DEPTH];
  logic [31:0] m_cnt;
  bit          m_lock_ack;

  function automatic string fmt(xres_t r);
    return $sformatf("resp=%0d lat=%0d dat=%h tag=%h bad=%0b", r.resp, r.lat, r.rd, r.rt, r.bad);
  endfunction

  task automatic model_xfer(input bit we, input logic [63:0] adr, input logic [63:0] dat,
                            input logic [7:0] sel, input logic [15:0] tgd,
                            input bit lk, input bit rty, output xres_t e);
    logic [63:0] widx;
    int          i;
    widx = adr >> 3;
    e = '0;
    e.resp = rty ? 2'd3 : ((widx >= 64'(DEPTH)) || (sel == 8'h00)) ? 2'd2 : 2'd1;
    e.lat  = (lk && m_lock_ack) ? 8'd1 : 8'(WS + 1);
    if (e.resp == 2'd1) begin
      i = int'(widx);
      m_cnt = m_cnt + 32'd1;
      if (we) begin
        for (int b = 0; b < 8; b++) if (sel[b]) m_data[i][b*8 +: 8] = dat[b*8 +: 8];
        m_tag[i] = tgd;
      end else begin
        e.rd = m_data[i];
        e.rt = m_tag[i];
      end
    end
    m_lock_ack = lk && (e.resp == 2'd1);
  endtask

  task automatic do_xfer(input bit we, input logic [63:0] adr, input logic [63:0] dat,
                         input logic [7:0] sel, input logic [15:0] tgd,
                         input bit lk, input bit rty, output xres_t g);
    bit done;
    done = 1'b0;
    g = '0;
    @(negedge clk);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = dat; SEL_I = sel;
    TGD_I = tgd; LOCK_I = lk; rty_req = rty; TGA_I = 16'($urandom); TGC_I = 16'($urandom);
    @(posedge clk); #1;
    STB_I = 1'b0; rty_req = 1'b0;
    for (int n = 1; n <= 40 && !done; n++) begin
      if (ACK_O || ERR_O || RTY_O) begin
        done   = 1'b1;
        g.lat  = 8'(n);
        g.resp = ACK_O ? 2'd1 : ERR_O ? 2'd2 : 2'd3;
        g.rd   = DAT_O;
        g.rt   = TGD_O;
        if ($countones({ACK_O, ERR_O, RTY_O}) > 1) g.bad = 1'b1;
      end else begin
        if (DAT_O != '0 || TGD_O != '0) g.bad = 1'b1;
        @(posedge clk); #1;
      end
    end
    CYC_I = 1'b0; WE_I = 1'b0; LOCK_I = 1'b0;
    @(posedge clk);
  endtask

  task automatic xfer(input bit we, input logic [63:0] adr, input logic [63:0] dat,
                      input logic [7:0] sel, input logic [15:0] tgd,
                      input bit lk, input bit rty, output xres_t g, output xres_t e);
    model_xfer(we, adr, dat, sel, tgd, lk, rty, e);
    do_xfer(we, adr, dat, sel, tgd, lk, rty, g);
  endtask

  task automatic test_reset();
    rst = 1'b1; RST_I = 1'b0; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; LOCK_I = 1'b0;
    rty_req = 1'b0; ADR_I = '0; DAT_I = '0; SEL_I = '0; TGA_I = '0; TGC_I = '0; TGD_I = '0;
    m_cnt = '0; m_lock_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({ACK_O, ERR_O, RTY_O} !== 3'b000) begin errors++; $display("FAIL reset_terms: got %b expected 000", {ACK_O, ERR_O, RTY_O}); end
    checks++; if (DAT_O !== '0) begin errors++; $display("FAIL reset_dat: got %h expected 0", DAT_O); end
    checks++; if (TGD_O !== '0) begin errors++; $display("FAIL reset_tgd: got %h expected 0", TGD_O); end
    checks++; if (xfer_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %h expected 0", xfer_cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    xres_t g, e;
    xfer(1'b1, 64'h10, 64'h1122334455667788, 8'hFF, 16'hBEEF, 1'b0, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL wr_basic: got %s, expected %s", fmt(g), fmt(e)); end
    xfer(1'b0, 64'h10, 64'h0, 8'hFF, 16'h0, 1'b0, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL rd_basic: got %s, expected %s", fmt(g), fmt(e)); end
    @(negedge clk);
    checks++; if (xfer_cnt !== m_cnt) begin errors++; $display("FAIL cnt_basic: got %0d expected %0d", xfer_cnt, m_cnt); end
  endtask

  task automatic test_byte_lanes();
    xres_t g, e;
    xfer(1'b1, 64'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 16'h1234, 1'b0, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL lane_wr: got %s, expected %s", fmt(g), fmt(e)); end
    xfer(1'b0, 64'h13, 64'h0, 8'hFF, 16'h0, 1'b0, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL lane_rd: got %s, expected %s", fmt(g), fmt(e)); end
  endtask

  task automatic test_errors();
    xres_t g, e;
    xfer(1'b1, 64'h0, 64'hCAFEF00DDEADC0DE, 8'hFF, 16'h0101, 1'b0, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL err_init: got %s, expected %s", fmt(g), fmt(e)); end
    xfer(1'b1, 64'(DEPTH * 8), 64'h0123456789ABCDEF, 8'hFF, 16'h2222, 1'b0, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL err_adr: got %s, expected %s", fmt(g), fmt(e)); end
    @(negedge clk);
    checks++; if (xfer_cnt !== m_cnt) begin errors++; $display("FAIL err_cnt: got %0d expected %0d", xfer_cnt, m_cnt); end
    xfer(1'b0, 64'h0, 64'h0, 8'hFF, 16'h0, 1'b0, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL err_adr_mem: got %s, expected %s", fmt(g), fmt(e)); end
    xfer(1'b1, 64'h10, 64'h5A5A5A5A5A5A5A5A, 8'h00, 16'hDEAD, 1'b0, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL err_sel0: got %s, expected %s", fmt(g), fmt(e)); end
    xfer(1'b0, 64'h10, 64'h0, 8'hFF, 16'h0, 1'b0, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL err_sel0_mem: got %s, expected %s", fmt(g), fmt(e)); end
    xfer(1'b1, 64'(DEPTH * 8), 64'h1, 8'hFF, 16'h3333, 1'b0, 1'b1, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL rty_bad_adr: got %s, expected %s", fmt(g), fmt(e)); end
    xfer(1'b1, 64'h10, 64'h7777777777777777, 8'hFF, 16'h4444, 1'b0, 1'b1, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL rty_good_adr: got %s, expected %s", fmt(g), fmt(e)); end
    xfer(1'b0, 64'h10, 64'h0, 8'hFF, 16'h0, 1'b0, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL rty_mem: got %s, expected %s", fmt(g), fmt(e)); end
  endtask

  task automatic test_locked_burst();
    xres_t g, e;
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, (i % 2 == 0) ? 64'h10 : 64'h0, 64'h0, 8'hFF, 16'h0, 1'b1, 1'b0, g, e);
      checks++; if (g !== e) begin errors++; $display("FAIL lock_burst_%0d: got %s, expected %s", i, fmt(g), fmt(e)); end
    end
    xfer(1'b0, 64'h10, 64'h0, 8'hFF, 16'h0, 1'b0, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL lock_dropped: got %s, expected %s", fmt(g), fmt(e)); end
    xfer(1'b1, 64'h8, 64'h0F0F0F0F0F0F0F0F, 8'hFF, 16'h5151, 1'b1, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL lock_restart: got %s, expected %s", fmt(g), fmt(e)); end
    xfer(1'b1, 64'h8, 64'hF0F0F0F0F0F0F0F0, 8'hF0, 16'h5252, 1'b1, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL lock_fast_wr: got %s, expected %s", fmt(g), fmt(e)); end
    xfer(1'b0, 64'(DEPTH * 8), 64'h0, 8'hFF, 16'h0, 1'b1, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL lock_err: got %s, expected %s", fmt(g), fmt(e)); end
    xfer(1'b0, 64'h8, 64'h0, 8'hFF, 16'h0, 1'b1, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL lock_after_err: got %s, expected %s", fmt(g), fmt(e)); end
  endtask

  task automatic test_abort();
    xres_t g, e;
    bit    seen;
    seen = 1'b0;
    @(negedge clk);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 64'h10; DAT_I = 64'h5555555555555555;
    SEL_I = 8'hFF; TGD_I = 16'h7777; LOCK_I = 1'b0;
    @(posedge clk); #1;
    STB_I = 1'b0;
    @(negedge clk);
    CYC_I = 1'b0; WE_I = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ACK_O || ERR_O || RTY_O) seen = 1'b1;
    end
    m_lock_ack = 1'b0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_term: got termination=%0b expected 0", seen); end
    xfer(1'b0, 64'h10, 64'h0, 8'hFF, 16'h0, 1'b0, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL abort_mem: got %s, expected %s", fmt(g), fmt(e)); end
  endtask

  task automatic test_async_reset();
    xres_t g, e;
    bit    got_ack;
    // Reset asserted while a write is waiting.
    @(negedge clk);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 64'h10; DAT_I = 64'h6666666666666666;
    SEL_I = 8'hFF; TGD_I = 16'h6666;
    @(posedge clk); #1;
    STB_I = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if ({ACK_O, ERR_O, RTY_O, DAT_O, TGD_O, xfer_cnt} !== '0) begin errors++; $display("FAIL rst_wait_outputs: got term=%b dat=%h tag=%h cnt=%0d expected all 0", {ACK_O, ERR_O, RTY_O}, DAT_O, TGD_O, xfer_cnt); end
    CYC_I = 1'b0; WE_I = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_cnt = '0; m_lock_ack = 1'b0;
    xfer(1'b0, 64'h10, 64'h0, 8'hFF, 16'h0, 1'b0, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL rst_wait_mem: got %s, expected %s", fmt(g), fmt(e)); end
    // Reset asserted while a read is being acknowledged.
    got_ack = 1'b0;
    @(negedge clk);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 64'h10; SEL_I = 8'hFF;
    @(posedge clk); #1;
    STB_I = 1'b0;
    for (int n = 0; n < 10 && !got_ack; n++) begin
      if (ACK_O) got_ack = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++; if (got_ack !== 1'b1) begin errors++; $display("FAIL rst_resp_reach: got ack=%0b expected 1", got_ack); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({ACK_O, ERR_O, RTY_O, DAT_O, TGD_O, xfer_cnt} !== '0) begin errors++; $display("FAIL rst_resp_outputs: got term=%b dat=%h tag=%h cnt=%0d expected all 0", {ACK_O, ERR_O, RTY_O}, DAT_O, TGD_O, xfer_cnt); end
    CYC_I = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_cnt = '0; m_lock_ack = 1'b0;
    xfer(1'b0, 64'h0, 64'h0, 8'hFF, 16'h0, 1'b1, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL rst_resume: got %s, expected %s", fmt(g), fmt(e)); end
  endtask

  task automatic test_sync_reset();
    xres_t g, e;
    bit    seen;
    seen = 1'b0;
    xfer(1'b0, 64'h10, 64'h0, 8'hFF, 16'h0, 1'b1, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL srst_pre: got %s, expected %s", fmt(g), fmt(e)); end
    @(negedge clk);
    RST_I = 1'b1; CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 64'h10;
    DAT_I = 64'h9999999999999999; SEL_I = 8'hFF; TGD_I = 16'h9999; LOCK_I = 1'b1;
    @(negedge clk);
    RST_I = 1'b0; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; LOCK_I = 1'b0;
    m_cnt = '0; m_lock_ack = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ACK_O || ERR_O || RTY_O) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL srst_term: got termination=%0b expected 0", seen); end
    checks++; if (xfer_cnt !== m_cnt) begin errors++; $display("FAIL srst_cnt: got %0d expected %0d", xfer_cnt, m_cnt); end
    xfer(1'b0, 64'h10, 64'h0, 8'hFF, 16'h0, 1'b1, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL srst_mem: got %s, expected %s", fmt(g), fmt(e)); end
  endtask

  task automatic test_random();
    xres_t       g, e;
    bit          we, lk, rty;
    logic [63:0] adr;
    logic [7:0]  sel;
    int          r;
    for (int i = 0; i < 8; i++) begin
      xfer(1'b1, 64'(i * 8), {$urandom, $urandom}, 8'hFF, 16'($urandom), 1'b0, 1'b0, g, e);
      checks++; if (g !== e) begin errors++; $display("FAIL rnd_init_%0d: got %s, expected %s", i, fmt(g), fmt(e)); end
    end
    for (int i = 0; i < 40; i++) begin
      we  = 1'($urandom);
      r   = int'($urandom_range(0, 9));
      if (r < 8)       adr = 64'(r * 8) + 64'($urandom_range(0, 7));
      else if (r == 8) adr = 64'((DEPTH + int'($urandom_range(0, 50))) * 8);
      else             adr = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      sel = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      lk  = ($urandom_range(0, 2) != 0);
      rty = ($urandom_range(0, 9) == 0);
      xfer(we, adr, {$urandom, $urandom}, sel, 16'($urandom), lk, rty, g, e);
      checks++; if (g !== e) begin errors++; $display("FAIL rnd_%0d we=%0b adr=%h sel=%h lk=%0b rty=%0b: got %s, expected %s", i, we, adr, sel, lk, rty, fmt(g), fmt(e)); end
    end
    @(negedge clk);
    checks++; if (xfer_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt: got %0d expected %0d", xfer_cnt, m_cnt); end
  endtask

  task automatic test_wrap();
    xres_t g, e;
    @(negedge clk);
    force dut.xfer_q = 32'hFFFF_FFFF;
    #1;
    release dut.xfer_q;
    m_cnt = 32'hFFFF_FFFF;
    xfer(1'b0, 64'h10, 64'h0, 8'hFF, 16'h0, 1'b0, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL wrap_xfer: got %s, expected %s", fmt(g), fmt(e)); end
    @(negedge clk);
    checks++; if (xfer_cnt !== m_cnt) begin errors++; $display("FAIL wrap_cnt: got %h expected %h", xfer_cnt, m_cnt); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_errors();
    test_locked_burst();
    test_abort();
    test_async_reset();
    test_sync_reset();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_slave_mem.md
# wb_slave_mem

Parametrised Wishbone B4 classic-cycle slave with an internal byte-enabled memory. It generalises the fixed 64-bit slave pin set to configurable data, address, tag and depth widths, and adds programmable wait states, ERR/RTY generation, a locked-burst fast path and a transfer counter. It is the DUT-side responder used behind the slave agent and as a memory model in the system-level environment.

## Interface
- `DW`, 64, data width; a multiple of 8, ≥ 8.
- `AW`, 64, byte address width.
- `TW`, 16, width of every tag bus.
- `DEPTH`, 256, number of `DW`-bit words in the memory.
- `WAIT_STATES`, 2, idle cycles inserted before each response; range 0..15.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous reset, active-high.
- `RST_I`  in  1  Wishbone synchronous reset, active-high; clears state, retains memory.
- `CYC_I`, `STB_I`, `WE_I`, `LOCK_I`  in  1 each  Wishbone cycle, strobe, write-enable and lock.
- `ADR_I`  in  AW  byte address.
- `DAT_I`  in  DW  write data.
- `SEL_I`  in  DW/8  byte-lane select.
- `TGA_I`, `TGC_I`, `TGD_I`  in  TW each  address, cycle and data tags; `TGD_I` is stored with each written word.
- `rty_req`  in  1  forces RTY for the request accepted in this cycle.
- `DAT_O`  out  DW  read data; 0 when not acknowledging a read.
- `TGD_O`  out  TW  tag stored with the read word; 0 otherwise.
- `ACK_O`, `ERR_O`, `RTY_O`  out  1 each  termination signals; one-hot or all zero.
- `xfer_cnt`  out  32  count of ACK-terminated transfers.

## Operation
- Word index = `ADR_I[AW-1:log2(DW/8)]`. Low address bits are ignored.
- FSM states:
  - IDLE: accepts when `CYC_I & STB_I`, capturing the address, data, SEL, WE, TGD and LOCK, and the classification.
  - IDLE → WAIT if the wait count > 0, else IDLE → RESP.
  - WAIT: counts down, then goes to RESP.
  - RESP: lasts exactly one cycle, then returns to IDLE.
- Classification priority is RTY > ERR > ACK:
  - RTY if `rty_req` is high at acceptance.
  - ERR if word index ≥ `DEPTH` or `SEL_I == 0`.
  - Otherwise ACK.
- Write (ACK only): at the edge entering RESP, only the bytes selected by SEL are written. The tag is stored whenever any byte is written. ERR and RTY writes have no effect.
- Read (ACK only): `DAT_O` and `TGD_O` are registered from the memory and are valid only while `ACK_O` is high.
- Locked fast path: the wait count is 0 for an acceptance where `LOCK_I` is high and the previous accepted transfer also had `LOCK_I` high and ended with ACK. Otherwise the wait count is `WAIT_STATES`.
- Abort: `CYC_I` low during WAIT returns the FSM to IDLE with no termination, no write and no count. CYC dropping during RESP has no effect on that cycle.
- `xfer_cnt` increments on every ACK cycle and wraps from 0xFFFF_FFFF to 0.
- `TGA_I` and `TGC_I` are accepted and ignored, reserved for decode.

## Timing
- On `rst` (asynchronous) or `RST_I` (synchronous), mid-transfer included:
  - FSM goes to IDLE.
  - All terminations are 0, `DAT_O` = 0, `TGD_O` = 0, `xfer_cnt` = 0.
  - The lock history is cleared.
  - An interrupted write is not performed.
  - Memory contents are left unchanged; after power-up they are undefined.
- `RST_I` takes priority over acceptance in the same cycle.
- Latency from the acceptance edge to termination high is `WAIT_STATES + 1` cycles, or 1 cycle on the locked fast path.
- Termination is high for exactly one cycle.
- Throughput is one transfer per `WAIT_STATES + 2` cycles, or 2 cycles when locked, because IDLE samples only on the edge after RESP.
- Inputs are ignored outside IDLE, except for the CYC abort check in WAIT.

## Structure
- `wb_pkg`:
  - the FSM state enum (IDLE, WAIT, RESP);
  - the response enum (NONE, ACK, ERR, RTY);
  - the `WAIT_W = 4` constant.
- Sub-module `wb_slave_bytemem`:
  - `DEPTH` × (`DW` + `TW`) array;
  - byte-enabled synchronous write;
  - registered read.
- Top level holds the FSM, wait counter, classifier, lock history and counter.

## Test plan
- Write/read with `WAIT_STATES = 2`:
  - write 0x1122334455667788 to ADR 0x10 with `SEL_I = 0xFF` and TGD 0xBEEF → ACK 3 cycles after acceptance;
  - read ADR 0x10 → `DAT_O` = 0x1122334455667788, `TGD_O` = 0xBEEF, `xfer_cnt` = 2.
- Byte lanes: over the word above, write 0xAA..AA with `SEL_I = 0x0F` → read returns 0x11223344AAAAAAAA.
- Errors:
  - ADR = `DEPTH * 8` → ERR, memory unchanged, `xfer_cnt` not incremented;
  - `SEL_I = 0` → ERR;
  - `rty_req = 1` with a bad address → RTY only.
- Locked burst: 4 reads with `LOCK_I` high → first terminates 3 cycles after acceptance, next three 1 cycle after acceptance; after `LOCK_I` drops → 3 cycles again.
- Abort and reset:
  - drop `CYC_I` in WAIT during a write → no termination, memory unchanged;
  - assert `rst` mid-WAIT → all outputs 0 on the same cycle, FSM IDLE;
  - `RST_I` with a simultaneous request → request ignored.
- Counter wrap: force `xfer_cnt` to 0xFFFFFFFF, then one ACK → `xfer_cnt` = 0.
